// File: rtl/risc_seq_pkg.sv
// Shared types and constants for the multi-cycle RISC-V control sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package risc_seq_pkg;

    // Sequencer phase encoding (3 bits, IDLE is the reset state).
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    // Opcode that stops the core.
    localparam logic [6:0] HALT_OPC_DEF = 7'b1111111;

    // Per-state strobe pattern. mem_phase is later qualified by the latched
    // read/write bits to form mem_rd / mem_wr.
    typedef struct packed {
        logic ir_load;
        logic mem_phase;
        logic reg_we;
        logic halted;
    } strobe_t;

    localparam strobe_t STB_NONE  = strobe_t'(4'b0000);
    localparam strobe_t STB_FETCH = strobe_t'(4'b1000);
    localparam strobe_t STB_MEM   = strobe_t'(4'b0100);
    localparam strobe_t STB_WB    = strobe_t'(4'b0010);
    localparam strobe_t STB_HALT  = strobe_t'(4'b0001);

    function automatic strobe_t state_strobes(input state_t s);
        strobe_t stb;
        stb = STB_NONE;
        case (s)
            S_FETCH:     stb = STB_FETCH;
            S_MEM:       stb = STB_MEM;
            S_WRITEBACK: stb = STB_WB;
            S_HALT:      stb = STB_HALT;
            default:     stb = STB_NONE;
        endcase
        return stb;
    endfunction

endpackage

// File: rtl/risc_pc_update.sv
// Next-PC arithmetic: pc + 1, or pc + signed br_off when the branch is taken.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: pc/br_off (PC_W) and take in; next_pc (PC_W) out.
module risc_pc_update #(
    parameter int PC_W = 4
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] br_off,
    input  logic            take,
    output logic [PC_W-1:0] next_pc
);

    // Adding a sign-extended offset modulo 2^PC_W is exactly a PC_W-bit add
    // of the two's-complement offset, so no explicit extension is needed.
    assign next_pc = take ? (pc + br_off) : (pc + PC_W'(1));

endmodule

// File: rtl/risc_sequencer.sv
// Multi-cycle sequencer owning the PC: FETCH/DECODE/EXECUTE/MEM/WRITEBACK, sticky HALT.
// Latency: FETCH->FETCH 3 (branch/no-write), 4 (ALU), 4+W (store), 5+W (load); HALT 2 after FETCH.
// Backpressure: MEM strobes held until mem_ready is sampled high; nothing else stalls.
// Ports: clk50/rst (async, active-high); opcode, ctl_* and alu_zero/br_off/mem_ready in;
//        pc, ir_load, mem_rd, mem_wr, reg_we, halted out (Moore, decoded from state).
// Option: define RISC_SEQ_PERF_EN to add the 32-bit instret and stall_cnt counter outputs.
module risc_sequencer
    import risc_seq_pkg::*;
#(
    parameter int         PC_W     = 4,
    parameter logic [6:0] HALT_OPC = HALT_OPC_DEF
) (
    input  logic            clk50,
    input  logic            rst,
    input  logic [6:0]      opcode,
    input  logic            ctl_branch,
    input  logic            ctl_mem_read,
    input  logic            ctl_mem_write,
    input  logic            ctl_reg_write,
    input  logic            alu_zero,
    input  logic [PC_W-1:0] br_off,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic            ir_load,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            reg_we,
    output logic            halted
`ifdef RISC_SEQ_PERF_EN
    ,
    output logic [31:0]     instret,
    output logic [31:0]     stall_cnt
`endif
);

    state_t          state;
    logic            branch_l, mem_read_l, mem_write_l, reg_write_l;
    logic            take_l;
    logic [PC_W-1:0] off_l;

    logic            take_now;
    logic            take_sel;
    logic [PC_W-1:0] off_sel;
    logic            pc_upd;
    logic [PC_W-1:0] next_pc;
    strobe_t         stb;

    assign take_now = branch_l & alu_zero;

    // The PC may be updated from EXECUTE directly (use live values) or later
    // from MEM/WRITEBACK (use what EXECUTE captured). The offset is captured
    // with take so a late update never depends on br_off outside EXECUTE.
    assign take_sel = (state == S_EXECUTE) ? take_now : take_l;
    assign off_sel  = (state == S_EXECUTE) ? br_off   : off_l;

    assign pc_upd =
        ((state == S_EXECUTE) && !(mem_read_l || mem_write_l) && !reg_write_l) ||
        ((state == S_MEM) && mem_ready && !(mem_read_l && reg_write_l)) ||
        (state == S_WRITEBACK);

    risc_pc_update #(.PC_W(PC_W)) u_pc_update (
        .pc      (pc),
        .br_off  (off_sel),
        .take    (take_sel),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            branch_l    <= 1'b0;
            mem_read_l  <= 1'b0;
            mem_write_l <= 1'b0;
            reg_write_l <= 1'b0;
            take_l      <= 1'b0;
            off_l       <= '0;
        end else begin
            if (pc_upd) begin
                pc <= next_pc;
            end
            case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    branch_l    <= ctl_branch;
                    mem_read_l  <= ctl_mem_read;
                    mem_write_l <= ctl_mem_write;
                    reg_write_l <= ctl_reg_write;
                    state       <= (opcode == HALT_OPC) ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    take_l <= take_now;
                    off_l  <= br_off;
                    if (mem_read_l || mem_write_l) begin
                        state <= S_MEM;
                    end else if (reg_write_l) begin
                        state <= S_WRITEBACK;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= (mem_read_l && reg_write_l) ? S_WRITEBACK : S_FETCH;
                    end
                end
                S_WRITEBACK: state <= S_FETCH;
                S_HALT:      state <= S_HALT;
                default:     state <= S_IDLE;
            endcase
        end
    end

    // Strobes come straight off the state register, so reset clears them
    // asynchronously. A latched read+write pair drives both strobes as-is.
    assign stb     = state_strobes(state);
    assign ir_load = stb.ir_load;
    assign mem_rd  = stb.mem_phase & mem_read_l;
    assign mem_wr  = stb.mem_phase & mem_write_l;
    assign reg_we  = stb.reg_we;
    assign halted  = stb.halted;

`ifdef RISC_SEQ_PERF_EN
    // Neither counter can step in HALT: no PC update and no MEM cycle there.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            instret   <= '0;
            stall_cnt <= '0;
        end else begin
            if (pc_upd) begin
                instret <= instret + 32'd1;
            end
            if ((state == S_MEM) && !mem_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_risc_sequencer.sv
// Self-checking bench for risc_sequencer: per-instruction expected phase lists.
// Latency: n/a.
// Backpressure: mem_ready wait counts are chosen per instruction by the bench.
module tb_risc_sequencer;

    localparam int         PC_W     = 4;
    localparam logic [6:0] HALT_OPC = 7'h7F;

    logic            clk50 = 1'b0;
    logic            rst   = 1'b0;
    logic [6:0]      opcode = '0;
    logic            ctl_branch = 1'b0, ctl_mem_read = 1'b0, ctl_mem_write = 1'b0, ctl_reg_write = 1'b0;
    logic            alu_zero = 1'b0;
    logic [PC_W-1:0] br_off = '0;
    logic            mem_ready = 1'b0;
    logic [PC_W-1:0] pc;
    logic            ir_load, mem_rd, mem_wr, reg_we, halted;
`ifdef RISC_SEQ_PERF_EN
    logic [31:0]     instret, stall_cnt;
`endif

    risc_sequencer #(.PC_W(PC_W), .HALT_OPC(HALT_OPC)) dut (
        .clk50         (clk50),
        .rst           (rst),
        .opcode        (opcode),
        .ctl_branch    (ctl_branch),
        .ctl_mem_read  (ctl_mem_read),
        .ctl_mem_write (ctl_mem_write),
        .ctl_reg_write (ctl_reg_write),
        .alu_zero      (alu_zero),
        .br_off        (br_off),
        .mem_ready     (mem_ready),
        .pc            (pc),
        .ir_load       (ir_load),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .reg_we        (reg_we),
        .halted        (halted)
`ifdef RISC_SEQ_PERF_EN
        ,
        .instret       (instret),
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk50 = ~clk50;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: where the program counter should be, and the counters
    // accumulated since the last reset.
    logic [PC_W-1:0] m_pc;
    int unsigned     m_instret;
    int unsigned     m_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({pc, ir_load, mem_rd, mem_wr, reg_we, halted});
    endfunction

    function automatic logic [31:0] exp_v(input logic [PC_W-1:0] p, input logic ir,
                                          input logic rd, input logic wr, input logic we,
                                          input logic h);
        return 32'({p, ir, rd, wr, we, h});
    endfunction

    // Inputs the sequencer must ignore in the current phase get random values.
    task automatic junk();
        ctl_branch    = 1'($urandom);
        ctl_mem_read  = 1'($urandom);
        ctl_mem_write = 1'($urandom);
        ctl_reg_write = 1'($urandom);
        alu_zero      = 1'($urandom);
        mem_ready     = 1'($urandom);
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [31:0] exp);
        @(negedge clk50);
        chk(tag, outs(), exp);
        @(posedge clk50);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_async", outs(), 32'd0);
        repeat (2) @(posedge clk50);
        @(negedge clk50);
        chk("rst_hold", outs(), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle", outs(), 32'd0);
        @(posedge clk50);
        #1;
        m_pc      = '0;
        m_instret = 0;
        m_stall   = 0;
    endtask

    // One instruction, entered just after the edge that starts FETCH.
    task automatic run_instr(input logic br, input logic rd, input logic wr, input logic rw,
                             input logic z, input logic [PC_W-1:0] off, input int w);
        logic [PC_W-1:0] p0;
        logic            take;
        logic            do_wb;
        p0 = m_pc;
        br_off = off;
        junk();
        opcode = 7'($urandom);
        cyc("fetch", exp_v(p0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        junk();
        ctl_branch = br; ctl_mem_read = rd; ctl_mem_write = wr; ctl_reg_write = rw;
        opcode = 7'($urandom_range(0, 126));
        cyc("decode", exp_v(p0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        junk();
        alu_zero = z;
        cyc("execute", exp_v(p0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (rd || wr) begin
            for (int k = 0; k <= w; k++) begin
                junk();
                mem_ready = (k == w);
                if (k < w) m_stall++;
                cyc("mem", exp_v(p0, 1'b0, rd, wr, 1'b0, 1'b0));
            end
            do_wb = rd && rw;
        end else begin
            do_wb = rw;
        end
        if (do_wb) begin
            junk();
            cyc("writeback", exp_v(p0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        take = br && z;
        m_pc = take ? PC_W'(p0 + off) : PC_W'(p0 + 1);
        m_instret++;
    endtask

    task automatic run_random();
        run_instr(1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  1'($urandom), 1'($urandom), PC_W'($urandom), int'($urandom_range(0, 3)));
    endtask

    // Store stalled in MEM, then reset asserted asynchronously mid-cycle.
    task automatic reset_mid_mem();
        logic [PC_W-1:0] p0;
        p0 = m_pc;
        br_off = '0;
        junk();
        cyc("rm_fetch", exp_v(p0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        junk();
        ctl_branch = 1'b0; ctl_mem_read = 1'b0; ctl_mem_write = 1'b1; ctl_reg_write = 1'b0;
        opcode = 7'h23;
        cyc("rm_decode", exp_v(p0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        junk();
        cyc("rm_execute", exp_v(p0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        junk();
        mem_ready = 1'b0;
        cyc("rm_mem", exp_v(p0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        #1;
        chk("rm_mem_wr_pre", 32'(mem_wr), 32'd1);
        do_reset();
    endtask

    task automatic check_perf(input string tag);
`ifdef RISC_SEQ_PERF_EN
        chk({tag, "_instret"}, instret, m_instret);
        chk({tag, "_stall"}, stall_cnt, m_stall);
`else
        if (tag.len() == 0) $display("perf counters not built");
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PC_W-1:0] p0;
        #2;
        do_reset();

        // Three ALU ops, then branches around the address space edges.
        repeat (3) run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 0);
        chk("pc_after_alu", 32'(pc), 32'd3);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 0);   // pc 3, off -3
        chk("pc_branch_back", 32'(pc), 32'd0);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 0);   // pc 0, off -1
        chk("pc_branch_neg", 32'(pc), 32'd15);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 0);   // not taken at 15
        chk("pc_wrap", 32'(pc), 32'd0);
        run_instr(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 2);     // load, 2 wait cycles
        check_perf("directed");

        repeat (150) run_random();
        check_perf("random");

        reset_mid_mem();
        check_perf("after_rst");
        repeat (3) run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 0);
        run_instr(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 2);
        repeat (10) run_random();
        check_perf("pre_halt");

        // Halt: frozen pc, only halted asserted, counters frozen.
        p0 = m_pc;
        junk();
        opcode = 7'($urandom);
        cyc("h_fetch", exp_v(p0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        junk();
        opcode = HALT_OPC;
        cyc("h_decode", exp_v(p0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 22; i++) begin
            junk();
            opcode = 7'($urandom);
            br_off = PC_W'($urandom);
            cyc("halt", exp_v(p0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        check_perf("halted");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
